// File: rtl/syscall_unit.sv
// syscall_unit: services print_int, print_string, exit and print_char
// syscalls for the pipelined core. Stalls decode while busy, walks data
// memory word by word for strings and streams bytes/integers on a
// valid/ready channel.
// Optional feature macro: SYSCALL_PRINT_INT_EN enables code 1 (print_int).
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for a supported syscall in decode
// FETCH  | issue word read at {ptr[31:2],2'b00}
// WAIT   | capture returned memory word into word_buf
// EMIT   | present current string byte; NUL or length cap ends it
// INT    | present latched char/integer until accepted
// DONE   | one cycle with stall low so the pipeline moves past
// HALT   | program exited; stall and halt held until reset
module syscall_unit #(
  parameter int MAX_STR_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_is_int,
  output logic        stall,
  output logic        halt
);

  localparam int CW = $clog2(MAX_STR_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_INT, S_DONE, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] ptr, ptr_nxt;
  logic [31:0] word_buf, word_buf_nxt;
  logic [CW-1:0] count, count_nxt;
  logic        code_int, code_str, code_exit, code_char, supported;
  logic [7:0]  cur_byte;

`ifdef SYSCALL_PRINT_INT_EN
  logic        int_mode, int_mode_nxt;
  assign code_int = (v0 == 32'd1);
`else
  assign code_int = 1'b0;
`endif

  assign code_str  = (v0 == 32'd4);
  assign code_exit = (v0 == 32'd10);
  assign code_char = (v0 == 32'd11);
  assign supported = code_int | code_str | code_exit | code_char;

  // Byte lanes are little-endian: ptr[1:0] selects the lane.
  assign cur_byte = word_buf[{ptr[1:0], 3'b000} +: 8];

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      word_buf <= '0;
      count    <= '0;
`ifdef SYSCALL_PRINT_INT_EN
      int_mode <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      word_buf <= word_buf_nxt;
      count    <= count_nxt;
`ifdef SYSCALL_PRINT_INT_EN
      int_mode <= int_mode_nxt;
`endif
    end
  end

  // Next-state logic and all outputs; outputs derive from registered
  // state so they stay stable while the consumer backpressures.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    word_buf_nxt = word_buf;
    count_nxt    = count;
`ifdef SYSCALL_PRINT_INT_EN
    int_mode_nxt = int_mode;
`endif
    mem_rd       = 1'b0;
    mem_addr     = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    stall        = 1'b0;
    halt         = 1'b0;
    case (state)
      S_IDLE: begin
        if (syscall && supported) begin
          stall     = 1'b1;
          ptr_nxt   = a0;
          count_nxt = '0;
`ifdef SYSCALL_PRINT_INT_EN
          int_mode_nxt = code_int;
`endif
          if (code_str)       state_nxt = S_FETCH;
          else if (code_exit) state_nxt = S_HALT;
          else                state_nxt = S_INT;
        end
      end
      S_FETCH: begin
        stall     = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = {ptr[31:2], 2'b00};
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        stall        = 1'b1;
        word_buf_nxt = mem_data;
        state_nxt    = S_EMIT;
      end
      S_EMIT: begin
        stall = 1'b1;
        if (cur_byte == 8'h00) begin
          state_nxt = S_DONE;
        end else begin
          out_valid = 1'b1;
          out_data  = {24'h0, cur_byte};
          if (out_ready) begin
            ptr_nxt   = ptr + 32'd1;
            count_nxt = count + 1'b1;
            if (count_nxt == CW'(MAX_STR_LEN)) state_nxt = S_DONE;
            else if (ptr_nxt[1:0] == 2'b00)    state_nxt = S_FETCH;
          end
        end
      end
      S_INT: begin
        stall     = 1'b1;
        out_valid = 1'b1;
`ifdef SYSCALL_PRINT_INT_EN
        out_data  = int_mode ? ptr : {24'h0, ptr[7:0]};
`else
        out_data  = {24'h0, ptr[7:0]};
`endif
        if (out_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_HALT: begin
        stall = 1'b1;
        halt  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SYSCALL_PRINT_INT_EN
  assign out_is_int = (state == S_INT) && int_mode;
`else
  assign out_is_int = 1'b0;
`endif

endmodule
